fetch_ctrl: RTL and testbench

Instruction-fetch sequencer that drives the program counter and delivers instructions downstream. It consumes `prog_ctr` from the PC and drives the PC's `nextFlag`, `absjump_en` and `target` inputs. It reads a synchronous instruction ROM and presents each instruction on a valid/ready handshake to decode. It also handles taken-branch redirects from execute and stops fetching on a halt opcode.

---
 rtl/fetch_ctrl.sv | 141 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: paces the PC, reads the synchronous instruction ROM,
// hands each instruction to decode on valid/ready, redirects on jumps and stops on halt.
module fetch_ctrl #(
  parameter int             D       = 12,
  parameter int             W       = 9,
  parameter int             PC_LAT  = 2,
  parameter logic [W-1:0]   HALT_OP = 9'h1FF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [D-1:0] prog_ctr,
  output logic         nextFlag,
  output logic         absjump_en,
  output logic [D-1:0] target,
  output logic [D-1:0] imem_addr,
  input  logic [W-1:0] imem_rdata,
  output logic [W-1:0] instr,
  output logic         instr_valid,
  input  logic         instr_ready,
  input  logic         jump_req,
  input  logic [D-1:0] jump_target,
  output logic         halt,
  output logic [15:0]  fetch_count
);

  localparam int            CW       = (PC_LAT > 1) ? $clog2(PC_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(PC_LAT - 1);

  typedef enum logic [2:0] {
    WAIT_PC,
    ISSUE,
    CAPTURE,
    HOLD,
    HALTED
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          nextflag_q, nextflag_d;
  logic          absjump_q, absjump_d;
  logic [D-1:0]  target_q, target_d;
  logic [W-1:0]  instr_q, instr_d;
  logic          instr_valid_q, instr_valid_d;
  logic          halt_q, halt_d;
  logic [15:0]   fetch_count_q, fetch_count_d;

  assign imem_addr   = prog_ctr;
  assign nextFlag    = nextflag_q;
  assign absjump_en  = absjump_q;
  assign target      = target_q;
  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign halt        = halt_q;
  assign fetch_count = fetch_count_q;

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    nextflag_d    = 1'b0;
    absjump_d     = 1'b0;
    target_d      = target_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    halt_d        = halt_q;
    fetch_count_d = fetch_count_q;

    // A redirect beats everything else, including a same-cycle handshake or halt opcode.
    if (state_q != HALTED && jump_req) begin
      absjump_d     = 1'b1;
      target_d      = jump_target;
      instr_valid_d = 1'b0;
      wait_cnt_d    = CNT_INIT;
      state_d       = WAIT_PC;
    end else begin
      case (state_q)
        WAIT_PC: begin
          if (wait_cnt_q == '0) begin
            state_d = ISSUE;
          end else begin
            wait_cnt_d = wait_cnt_q - CW'(1);
          end
        end
        ISSUE: begin
          state_d = CAPTURE;
        end
        CAPTURE: begin
          if (imem_rdata == HALT_OP) begin
            halt_d  = 1'b1;
            state_d = HALTED;
          end else begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (instr_valid_q && instr_ready) begin
            nextflag_d    = 1'b1;
            instr_valid_d = 1'b0;
            if (fetch_count_q != 16'hFFFF) begin
              fetch_count_d = fetch_count_q + 16'd1;
            end
            wait_cnt_d    = CNT_INIT;
            state_d       = WAIT_PC;
          end
        end
        HALTED: begin
          state_d = HALTED;
        end
        default: begin
          state_d = WAIT_PC;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= WAIT_PC;
      wait_cnt_q    <= CNT_INIT;
      nextflag_q    <= 1'b0;
      absjump_q     <= 1'b0;
      target_q      <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      halt_q        <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      nextflag_q    <= nextflag_d;
      absjump_q     <= absjump_d;
      target_q      <= target_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      halt_q        <= halt_d;
      fetch_count_q <= fetch_count_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: synchronous ROM and latency-2 PC around the DUT, with a
// transaction-level reference model that predicts every output each cycle.
module tb_fetch_ctrl;
  localparam int           D       = 12;
  localparam int           W       = 9;
  localparam int           PC_LAT  = 2;
  localparam logic [W-1:0] HALT_OP = 9'h1FF;

  logic         clk = 1'b0;
  logic         reset;
  logic [D-1:0] prog_ctr;
  logic         nextFlag;
  logic         absjump_en;
  logic [D-1:0] target;
  logic [D-1:0] imem_addr;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] instr;
  logic         instr_valid;
  logic         instr_ready;
  logic         jump_req;
  logic [D-1:0] jump_target;
  logic         halt;
  logic [15:0]  fetch_count;

  fetch_ctrl #(.D(D), .W(W), .PC_LAT(PC_LAT), .HALT_OP(HALT_OP)) dut (
    .clk(clk), .reset(reset), .prog_ctr(prog_ctr), .nextFlag(nextFlag),
    .absjump_en(absjump_en), .target(target), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .jump_req(jump_req), .jump_target(jump_target),
    .halt(halt), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data appears one cycle after the address.
  logic [W-1:0] rom [0:(1<<D)-1];
  always @(posedge clk) imem_rdata <= rom[imem_addr];

  // PC: a request seen on one edge takes effect two edges later.
  logic         inc_d1, ld_d1;
  logic [D-1:0] tgt_d1;
  always @(posedge clk) begin
    if (!reset) begin
      prog_ctr <= '0;
      inc_d1   <= 1'b0;
      ld_d1    <= 1'b0;
      tgt_d1   <= '0;
    end else begin
      inc_d1 <= nextFlag;
      ld_d1  <= absjump_en;
      tgt_d1 <= target;
      if (ld_d1)       prog_ctr <= tgt_d1;
      else if (inc_d1) prog_ctr <= prog_ctr + 1'b1;
    end
  end

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: program-order address plus the cycle at which the next fetch lands.
  int           fetch_at = 0;
  logic [D-1:0] m_pc     = '0;
  logic         e_valid  = 1'b0;
  logic         e_nf     = 1'b0;
  logic         e_abs    = 1'b0;
  logic         e_halt   = 1'b0;
  logic [D-1:0] e_target = '0;
  logic [W-1:0] e_instr  = '0;
  logic [15:0]  e_count  = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_step();
    int nc;
    nc    = cyc + 1;
    e_nf  = 1'b0;
    e_abs = 1'b0;
    if (!reset) begin
      e_valid  = 1'b0;
      e_halt   = 1'b0;
      e_target = '0;
      e_instr  = '0;
      e_count  = '0;
      m_pc     = '0;
      fetch_at = nc + PC_LAT + 2;
    end else if (e_halt) begin
      e_valid = 1'b0;
    end else if (jump_req) begin
      e_abs    = 1'b1;
      e_target = jump_target;
      e_valid  = 1'b0;
      m_pc     = jump_target;
      fetch_at = nc + PC_LAT + 2;
    end else if (e_valid && instr_ready) begin
      e_nf    = 1'b1;
      e_valid = 1'b0;
      if (e_count != 16'hFFFF) e_count = e_count + 16'd1;
      m_pc     = m_pc + 1'b1;
      fetch_at = nc + PC_LAT + 2;
    end else if (!e_valid && nc == fetch_at) begin
      if (rom[m_pc] == HALT_OP) begin
        e_halt = 1'b1;
      end else begin
        e_valid = 1'b1;
        e_instr = rom[m_pc];
      end
    end
    cyc = nc;
  endtask

  task automatic check_all();
    chk("instr_valid", instr_valid, e_valid);
    chk("nextFlag", nextFlag, e_nf);
    chk("absjump_en", absjump_en, e_abs);
    chk("target", target, e_target);
    chk("halt", halt, e_halt);
    chk("fetch_count", fetch_count, e_count);
    chk("imem_addr", imem_addr, prog_ctr);
    if (e_valid) chk("instr", instr, e_instr);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic wait_valid(input int bound, input string tag);
    for (int i = 0; i < bound && !instr_valid; i++) tick();
    chk(tag, instr_valid, 1);
  endtask

  task automatic do_reset(input int n);
    reset       = 1'b0;
    jump_req    = 1'b0;
    instr_ready = 1'b0;
    repeat (n) tick();
    reset = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, last, n_nf, jc;
    reset       = 1'b0;
    instr_ready = 1'b0;
    jump_req    = 1'b0;
    jump_target = '0;
    for (int i = 0; i < (1 << D); i++) rom[i] = W'($urandom_range(0, 9'h1FE));
    rom[0] = 9'h012;
    @(negedge clk);

    // Reset and startup latency
    do_reset(2);
    chk("rst_instr", instr, 0);
    r0 = cyc;
    wait_valid(12, "startup_timeout");
    chk("startup_cycle", cyc - r0, PC_LAT + 2);
    chk("startup_instr", instr, 9'h012);

    // Streaming with decode always ready
    for (int i = 0; i < 8; i++) rom[i] = W'(i + 1);
    rom[8]      = 9'h0C8;
    rom[9]      = 9'h0C9;
    rom[12'h0A0] = 9'h0AB;
    do_reset(2);
    instr_ready = 1'b1;
    last = 0;
    for (int i = 0; i < 8; i++) begin
      wait_valid(10, "stream_timeout");
      chk("stream_instr", instr, W'(i + 1));
      if (i > 0) chk("stream_gap", cyc - last, PC_LAT + 3);
      last = cyc;
      tick();
    end
    chk("stream_count", fetch_count, 8);

    // Backpressure
    instr_ready = 1'b0;
    wait_valid(10, "bp_timeout");
    repeat (6) begin
      tick();
      chk("bp_instr", instr, 9'h0C8);
      chk("bp_valid", instr_valid, 1);
      chk("bp_nextFlag", nextFlag, 0);
    end
    instr_ready = 1'b1;
    n_nf = 0;
    repeat (6) begin
      tick();
      instr_ready = 1'b0;
      if (nextFlag) n_nf++;
    end
    chk("bp_pulses", n_nf, 1);

    // Jump in the same cycle as a handshake
    wait_valid(10, "jh_timeout");
    chk("jh_pre_instr", instr, 9'h0C9);
    jump_req    = 1'b1;
    jump_target = 12'h0A0;
    instr_ready = 1'b1;
    jc = cyc;
    tick();
    jump_req    = 1'b0;
    instr_ready = 1'b0;
    chk("jh_absjump", absjump_en, 1);
    chk("jh_target", target, 12'h0A0);
    chk("jh_nextFlag", nextFlag, 0);
    chk("jh_count", fetch_count, 9);
    wait_valid(10, "jh_timeout2");
    chk("jh_latency", cyc - jc, PC_LAT + 3);
    chk("jh_instr", instr, 9'h0AB);

    // Reset while capturing
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("mid_valid", instr_valid, 0);
    chk("mid_count", fetch_count, 0);
    reset = 1'b1;
    r0 = cyc;
    wait_valid(12, "mid_timeout");
    chk("mid_cycle", cyc - r0, PC_LAT + 2);
    chk("mid_instr", instr, 9'h001);

    // Halt opcode at address 3
    rom[3] = HALT_OP;
    do_reset(2);
    instr_ready = 1'b1;
    for (int i = 0; i < 40 && !halt; i++) tick();
    chk("halt_set", halt, 1);
    chk("halt_count", fetch_count, 3);
    repeat (10) begin
      jump_req    = 1'b1;
      jump_target = 12'h010;
      tick();
      chk("halt_sticky", halt, 1);
      chk("halt_valid", instr_valid, 0);
      chk("halt_abs", absjump_en, 0);
    end
    jump_req = 1'b0;

    // Randomized traffic with occasional jumps and resets
    rom[3] = 9'h033;
    do_reset(2);
    repeat (2000) begin
      instr_ready = ($urandom_range(0, 3) != 0);
      jump_req    = ($urandom_range(0, 15) == 0);
      jump_target = D'($urandom_range(0, (1 << D) - 1));
      reset       = ($urandom_range(0, 299) != 0);
      tick();
    end
    reset    = 1'b1;
    jump_req = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
